ram_sdp_fifo_ctrl: RTL and testbench

First-word-fall-through FIFO controller that drives an external simple-dual-port RAM (one write port, one read port, one registered read cycle, read-before-write on address collision). It sits directly upstream of the RAM: converts push/pop handshakes into RAM write/read addresses, tracks occupancy, and presents the head word with zero pop-to-data latency. A write/read-collision bypass keeps data correct when a word is written and read in the same cycle.

---
 rtl/ram_sdp_fifo_ctrl_if.sv | 31 +++
 rtl/ram_sdp_fifo_ctrl.sv | 113 +++++++++++
 tb/tb_ram_sdp_fifo_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ram_sdp_fifo_ctrl_if.sv
// ram_sdp_fifo_ctrl_if: push/pop handshake, status and RAM-side bus of the FIFO controller.
//   slave  modport: the controller (push/pop inputs and RAM read data in; status, head data and RAM controls out)
//   master modport: the surrounding logic (drives push/pop and RAM read data; observes everything else)
interface ram_sdp_fifo_ctrl_if #(
   parameter int unsigned CAddrLen = 9,
   parameter int unsigned CDataLen = 32
);
   logic [CDataLen-1:0] AWrData;
   logic                AWrEn;
   logic                AFull;
   logic [CDataLen-1:0] ARdData;
   logic                ARdValid;
   logic                ARdEn;
   logic [CAddrLen:0]   ALevel;
   logic [CAddrLen-1:0] ARamAddrWr;
   logic [CAddrLen-1:0] ARamAddrRd;
   logic [CDataLen-1:0] ARamMosi;
   logic [CDataLen-1:0] ARamMiso;
   logic                ARamWrEn;
   logic [1:0]          AErr;

   modport slave (
      input  AWrData, AWrEn, ARdEn, ARamMiso,
      output AFull, ARdData, ARdValid, ALevel, ARamAddrWr, ARamAddrRd, ARamMosi, ARamWrEn, AErr
   );

   modport master (
      output AWrData, AWrEn, ARdEn, ARamMiso,
      input  AFull, ARdData, ARdValid, ALevel, ARamAddrWr, ARamAddrRd, ARamMosi, ARamWrEn, AErr
   );
endinterface

// File: rtl/ram_sdp_fifo_ctrl.sv
// ram_sdp_fifo_ctrl: first-word-fall-through FIFO controller for an external simple-dual-port
// RAM (registered read, read-before-write). Presents the head word with zero pop-to-data latency
// and bypasses same-cycle write/read address collisions.
// Ports:
//   AClkH    - clock, all state on rising edge
//   AResetH  - asynchronous active-high reset
//   AClkHEn  - clock enable; state advances only when 1
//   AFifo    - ram_sdp_fifo_ctrl_if.slave: push/pop handshake, level/full/valid, head data,
//              RAM write/read addresses, write data/strobe, RAM read data, error flags
// Optional feature: define RAM_FIFO_CTRL_ERR_EN to get sticky {overflow, underflow} flags on AErr;
// otherwise AErr is tied to 2'b00.
module ram_sdp_fifo_ctrl #(
   parameter int unsigned CAddrLen = 9,
   parameter int unsigned CDataLen = 32
) (
   input logic                 AClkH,
   input logic                 AResetH,
   input logic                 AClkHEn,
   ram_sdp_fifo_ctrl_if.slave  AFifo
);
   localparam int unsigned CLvlLen = CAddrLen + 1;
   localparam logic [CLvlLen-1:0]  CDepth   = CLvlLen'(2 ** CAddrLen);
   localparam logic [CLvlLen-1:0]  CLvlOne  = CLvlLen'(1);
   localparam logic [CAddrLen-1:0] CAddrOne = CAddrLen'(1);

   logic [CAddrLen-1:0] FWrPtr;
   logic [CAddrLen-1:0] FRdPtr;
   logic [CLvlLen-1:0]  FLevel;
   logic                FFull;
   logic                FValid;
   logic                FBypSel;
   logic [CDataLen-1:0] FBypData;

   logic                FPush;
   logic                FPop;
   logic                FCollide;
   logic [CAddrLen-1:0] FAddrRd;
   logic [CLvlLen-1:0]  FLevelNext;

   // Handshake acceptance uses registered status, so a push while full is dropped even with a pop.
   always_comb begin
      FPush      = AClkHEn & AFifo.AWrEn & ~FFull;
      FPop       = AClkHEn & AFifo.ARdEn & FValid;
      // Read ahead on pop so the registered RAM output shows the new head next cycle.
      FAddrRd    = FPop ? FRdPtr + CAddrOne : FRdPtr;
      FCollide   = FPush & (FWrPtr == FAddrRd);
      FLevelNext = FLevel;
      if (FPush && !FPop) begin
         FLevelNext = FLevel + CLvlOne;
      end else if (!FPush && FPop) begin
         FLevelNext = FLevel - CLvlOne;
      end
   end

   // Pointers, occupancy and collision bypass register.
   always_ff @(posedge AClkH or posedge AResetH) begin
      if (AResetH) begin
         FWrPtr   <= '0;
         FRdPtr   <= '0;
         FLevel   <= '0;
         FFull    <= 1'b0;
         FValid   <= 1'b0;
         FBypSel  <= 1'b0;
         FBypData <= '0;
      end else if (AClkHEn) begin
         if (FPush) begin
            FWrPtr <= FWrPtr + CAddrOne;
         end
         if (FPop) begin
            FRdPtr <= FRdPtr + CAddrOne;
         end
         FLevel  <= FLevelNext;
         FFull   <= (FLevelNext == CDepth);
         FValid  <= (FLevelNext != '0);
         // RAM returns the pre-write word on a collision, so remember the new word instead.
         FBypSel <= FCollide;
         if (FCollide) begin
            FBypData <= AFifo.AWrData;
         end
      end
   end

`ifdef RAM_FIFO_CTRL_ERR_EN
   logic [1:0] FErr;

   // Sticky {overflow, underflow} flags.
   always_ff @(posedge AClkH or posedge AResetH) begin
      if (AResetH) begin
         FErr <= 2'b00;
      end else begin
         if (AClkHEn & AFifo.AWrEn & FFull) begin
            FErr[1] <= 1'b1;
         end
         if (AClkHEn & AFifo.ARdEn & ~FValid) begin
            FErr[0] <= 1'b1;
         end
      end
   end

   assign AFifo.AErr = FErr;
`else
   assign AFifo.AErr = 2'b00;
`endif

   assign AFifo.ARamWrEn   = FPush & ~AResetH;
   assign AFifo.ARamAddrWr = FWrPtr;
   assign AFifo.ARamAddrRd = FAddrRd;
   assign AFifo.ARamMosi   = AFifo.AWrData;
   assign AFifo.AFull      = FFull;
   assign AFifo.ARdValid   = FValid;
   assign AFifo.ALevel     = FLevel;
   assign AFifo.ARdData    = FValid ? (FBypSel ? FBypData : AFifo.ARamMiso) : '0;
endmodule

// File: tb/tb_ram_sdp_fifo_ctrl.sv
// tb_ram_sdp_fifo_ctrl: directed bench for ram_sdp_fifo_ctrl with a queue-based reference model,
// a behavioural read-before-write RAM, a per-cycle compare process and literal spot checks.
module tb_ram_sdp_fifo_ctrl;
   localparam int unsigned CAddrLen = 9;
   localparam int unsigned CDataLen = 32;
   localparam int unsigned CDepth   = 2 ** CAddrLen;
`ifdef RAM_FIFO_CTRL_ERR_EN
   localparam bit CErrEn = 1'b1;
`else
   localparam bit CErrEn = 1'b0;
`endif

   logic AClkH   = 1'b0;
   logic AResetH = 1'b1;
   logic AClkHEn = 1'b0;

   ram_sdp_fifo_ctrl_if #(.CAddrLen(CAddrLen), .CDataLen(CDataLen)) bus ();

   ram_sdp_fifo_ctrl #(.CAddrLen(CAddrLen), .CDataLen(CDataLen)) dut (
      .AClkH   (AClkH),
      .AResetH (AResetH),
      .AClkHEn (AClkHEn),
      .AFifo   (bus)
   );

   always #5 AClkH = ~AClkH;

   // External SDP RAM: registered read, read-before-write on collision.
   logic [CDataLen-1:0] mem [CDepth];
   always @(posedge AClkH) begin
      bus.ARamMiso <= mem[bus.ARamAddrRd];
      if (bus.ARamWrEn) mem[bus.ARamAddrWr] <= bus.ARamMosi;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: word queue plus total push/pop counts.
   logic [CDataLen-1:0] q[$];
   int unsigned nPush = 0;
   int unsigned nPop  = 0;
   logic [1:0]  mErr  = 2'b00;

   always @(posedge AClkH or posedge AResetH) begin
      if (AResetH) begin
         q.delete();
         nPush = 0;
         nPop  = 0;
         mErr  = 2'b00;
      end else if (AClkHEn) begin
         bit doPush, doPop;
         doPush = bus.AWrEn && (q.size() < CDepth);
         doPop  = bus.ARdEn && (q.size() != 0);
         if (bus.AWrEn && q.size() == CDepth) mErr[1] = 1'b1;
         if (bus.ARdEn && q.size() == 0)      mErr[0] = 1'b1;
         if (doPop) begin
            void'(q.pop_front());
            nPop++;
         end
         if (doPush) begin
            q.push_back(bus.AWrData);
            nPush++;
         end
      end
   end

   // Per-cycle compare on the falling edge.
   always @(negedge AClkH) begin
      bit expPush, expPop;
      expPush = !AResetH && AClkHEn && bus.AWrEn && (q.size() < CDepth);
      expPop  = !AResetH && AClkHEn && bus.ARdEn && (q.size() != 0);
      chk("valid", 64'(bus.ARdValid), 64'(q.size() != 0));
      chk("level", 64'(bus.ALevel), 64'(q.size()));
      chk("full",  64'(bus.AFull),  64'(q.size() == CDepth));
      chk("rddata", 64'(bus.ARdData), (q.size() != 0) ? 64'(q[0]) : 64'd0);
      chk("ramwren", 64'(bus.ARamWrEn), 64'(expPush));
      if (expPush) chk("ramaddrwr", 64'(bus.ARamAddrWr), 64'(nPush % CDepth));
      if (expPush) chk("rammosi", 64'(bus.ARamMosi), 64'(bus.AWrData));
      chk("ramaddrrd", 64'(bus.ARamAddrRd), 64'((nPop + (expPop ? 1 : 0)) % CDepth));
      chk("err", 64'(bus.AErr), CErrEn ? 64'(mErr) : 64'd0);
   end

   // Drive one cycle of inputs, then land just after the next rising edge.
   task automatic step(input bit en, input bit wr, input bit rd, input logic [CDataLen-1:0] d);
      AClkHEn     = en;
      bus.AWrEn   = wr;
      bus.ARdEn   = rd;
      bus.AWrData = d;
      @(posedge AClkH);
      #2;
   endtask

   logic [CDataLen-1:0] held;

   initial begin
      bus.AWrEn   = 1'b0;
      bus.ARdEn   = 1'b0;
      bus.AWrData = '0;
      repeat (2) @(posedge AClkH);
      #2;
      chk("rst_valid", 64'(bus.ARdValid), 64'd0);
      chk("rst_level", 64'(bus.ALevel), 64'd0);
      chk("rst_rddata", 64'(bus.ARdData), 64'd0);
      AResetH = 1'b0;

      // Single push falls through to the head next cycle.
      step(1, 1, 0, 32'hA5A5_0001);
      chk("t1_valid", 64'(bus.ARdValid), 64'd1);
      chk("t1_data", 64'(bus.ARdData), 64'hA5A5_0001);
      chk("t1_level", 64'(bus.ALevel), 64'd1);
      step(1, 0, 1, '0);
      chk("t1_empty", 64'(bus.ARdValid), 64'd0);

      // Fill completely, overflow attempt, drain in order.
      for (int i = 0; i < int'(CDepth); i++) step(1, 1, 0, 32'(i));
      chk("t2_full", 64'(bus.AFull), 64'd1);
      chk("t2_level", 64'(bus.ALevel), 64'd512);
      step(1, 1, 0, 32'hDEAD_BEEF);
      chk("t2_level_ovf", 64'(bus.ALevel), 64'd512);
      chk("t2_err", 64'(bus.AErr), CErrEn ? 64'd2 : 64'd0);
      step(1, 1, 1, 32'hDEAD_0002);
      chk("t2_fullpop_level", 64'(bus.ALevel), 64'd511);
      chk("t2_fullpop_head", 64'(bus.ARdData), 64'd1);
      for (int i = 0; i < int'(CDepth) - 1; i++) step(1, 0, 1, '0);
      chk("t2_drained_valid", 64'(bus.ARdValid), 64'd0);
      chk("t2_drained_data", 64'(bus.ARdData), 64'd0);

      // Push+pop at level 1 takes the new word through the bypass.
      step(1, 1, 0, 32'h10);
      step(1, 1, 1, 32'h20);
      chk("t3_data", 64'(bus.ARdData), 64'h20);
      chk("t3_level", 64'(bus.ALevel), 64'd1);
      step(1, 0, 1, '0);

      // Push+pop on empty: only the push is taken.
      step(1, 1, 1, 32'h33);
      chk("t3b_level", 64'(bus.ALevel), 64'd1);
      chk("t3b_data", 64'(bus.ARdData), 64'h33);
      step(1, 0, 1, '0);

      // Sustained push+pop at level 3 across pointer wrap.
      for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h1000_0000 + 32'(i));
      for (int i = 3; i < 2003; i++) step(1, 1, 1, 32'h1000_0000 + 32'(i));
      chk("t4_level", 64'(bus.ALevel), 64'd3);
      chk("t4_head", 64'(bus.ARdData), 64'h1000_07D0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, '0);

      // Pop on empty.
      step(1, 0, 1, '0);
      chk("t5_level", 64'(bus.ALevel), 64'd0);
      chk("t5_err", 64'(bus.AErr), CErrEn ? 64'd3 : 64'd0);

      // Clock enable low freezes everything.
      for (int i = 0; i < 5; i++) step(1, 1, 0, 32'h5000_0000 + 32'(i));
      held = bus.ARdData;
      chk("t6_head", 64'(held), 64'h5000_0000);
      for (int i = 0; i < 10; i++) step(0, 1, 1, 32'hFFFF_0000 + 32'(i));
      chk("t6_level", 64'(bus.ALevel), 64'd5);
      chk("t6_stable", 64'(bus.ARdData), 64'(held));

      // Asynchronous reset mid-stream.
      AClkHEn     = 1'b1;
      bus.AWrEn   = 1'b1;
      bus.ARdEn   = 1'b0;
      bus.AWrData = 32'h7777_0000;
      #1;
      AResetH = 1'b1;
      #1;
      chk("t7_valid", 64'(bus.ARdValid), 64'd0);
      chk("t7_data", 64'(bus.ARdData), 64'd0);
      chk("t7_level", 64'(bus.ALevel), 64'd0);
      chk("t7_full", 64'(bus.AFull), 64'd0);
      chk("t7_wren", 64'(bus.ARamWrEn), 64'd0);
      chk("t7_err", 64'(bus.AErr), 64'd0);
      step(1, 1, 0, 32'h7777_0001);
      AResetH = 1'b0;
      step(1, 1, 0, 32'h7777_0002);
      chk("t7_post_data", 64'(bus.ARdData), 64'h7777_0002);
      chk("t7_post_level", 64'(bus.ALevel), 64'd1);
      step(1, 0, 0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
